alu_unit: RTL and testbench
===========================

# alu_unit

Sequenced 8-bit arithmetic/logic stage directly downstream of the CPU's bus registers. It consumes the A-input and B-input register outputs and computes one operation per request. The result and N/Z/C/V flags are held until the next result, for capture by the adder-hold and status registers. Decimal-mode (BCD) correction for ADD/SUB runs as an extra pipeline cycle.

## Interface
- WIDTH, 8, datapath width; only 8 is supported (BCD logic assumes two nibbles)
- clk  input  1  rising-edge clock
- nrst  input  1  reset, asynchronous, active-low
- aIn  input  WIDTH  operand A (A-input register busOutputs)
- bIn  input  WIDTH  operand B (B-input register busOutputs)
- carryIn  input  1  carry/borrow-in
- op  input  4  operation code, aluOp_t
- decimalEnable  input  1  BCD mode request (D flag)
- start  input  1  request; sampled only in IDLE
- busy  output  1  high in EXEC and ADJ
- valid  output  1  one-cycle pulse when result and flags update
- result  output  WIDTH  held result
- carryOut, overflowOut, negativeOut, zeroOut  output  1 each  held flags C, V, N, Z

## Operation
- op encoding: ADD=0, SUB=1, AND=2, OR=3, EOR=4, ASL=5, LSR=6, ROL=7, ROR=8, PASS=9. Codes 10–15 behave as PASS.
- FSM states:
  - IDLE: on start, latch aIn, bIn, carryIn, op and decimalEnable, then go to EXEC.
  - EXEC: compute the binary result into an internal register. Go to ADJ if decimal is active and the op is ADD/SUB; otherwise go to DONE.
  - ADJ: apply BCD correction, then go to DONE.
  - DONE: drive outputs, pulse valid, return to IDLE.
- ADD: A+B+Cin. C is bit 8 of the sum. V = (A[7]==B[7]) && (sum[7]!=A[7]).
- SUB: A+~B+Cin. C=1 means no borrow. V = (A[7]!=B[7]) && (diff[7]!=A[7]).
- AND/OR/EOR: bitwise A op B. C = Cin, V = 0.
- ASL/LSR/ROL/ROR operate on A:
  - ASL: C = A[7], bit 0 filled with 0.
  - LSR: C = A[0], bit 7 filled with 0.
  - ROL: C = A[7], Cin enters bit 0.
  - ROR: C = A[0], Cin enters bit 7.
  - V = 0 for all shifts.
- PASS: result = A, C = Cin, V = 0.
- N = result[7] and Z = (result==0), both from the final (post-adjust) result.
- Decimal ADD correction:
  - Add 6 to the low nibble if it is >9 or the binary half-carry was set.
  - Then add 0x60 if the high nibble is >9 or carry is set. In that case C=1.
- Decimal SUB correction:
  - Subtract 6 from the low nibble if a binary half-borrow occurred.
  - Subtract 0x60 if C=0.
  - C keeps its binary value.
- In decimal mode, V is taken from the binary intermediate value.
- Operands are invalid (BCD digits >9): the result is whatever the above rules produce. No error is flagged.

## Timing
- Latency from start (sampled in IDLE) to valid:
  - 3 cycles for binary ops (EXEC, DONE).
  - 4 cycles for decimal ADD/SUB (EXEC, ADJ, DONE).
- valid is high for exactly one cycle. result and flags change only in the cycle valid rises and hold afterwards.
- start while busy, or in DONE, is ignored and not queued. Back-to-back issue is possible from the cycle after DONE.
- Operand inputs may change after the start cycle; latched copies are used.
- Reset (asynchronous, any state, including mid-operation): state IDLE, result 0x00, all flags 0, busy 0, valid 0. An interrupted operation produces no valid.

## Configuration
- ALU_DECIMAL_MODE_EN:
  - Defined: ADJ state and BCD logic are compiled in; decimalEnable is honoured.
  - Undefined: decimalEnable is ignored, the ADJ state does not exist, and all ops take the binary path with 3-cycle latency.

## Structure
- Shared package cpu_pkg holds:
  - aluOp_t enum (4-bit, codes above).
  - aluState_t enum (IDLE, EXEC, ADJ, DONE).
  - Constant BCD_DIGIT_MAX = 9.
- Sub-module bcd_adjust, purely combinational, wrapped in ALU_DECIMAL_MODE_EN:
  - Inputs: binary result, half-carry, carry, isSub.
  - Outputs: adjusted result and carry.

## Test plan
- Binary ADD: A=0x50, B=0x50, Cin=0 → valid 3 cycles after start; result 0xA0, N=1, V=1, C=0, Z=0.
- Binary SUB: A=0x00, B=0x01, Cin=1 → result 0xFF, C=0, N=1, V=0.
- Decimal (macro defined): ADD 0x19+0x28, Cin=0 → 0x47, C=0, valid after 4 cycles. SUB 0x10−0x01, Cin=1 → 0x09, C=1. ADD 0x99+0x01 → 0x00, C=1, Z=1.
- Shifts: ROR A=0x01, Cin=1 → 0x80, C=1, N=1. ASL A=0x80 → 0x00, C=1, Z=1.
- start pulsed during EXEC is ignored: exactly one valid is produced and outputs reflect only the first request.
- nrst asserted during EXEC (decimal ADD in flight) → result 0x00, flags 0, busy 0 immediately; no valid after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, ALU sequencer states and BCD constants.
// ALU_DECIMAL_MODE_EN adds the ADJ state used by the decimal-correction cycle.
package cpu_pkg;

  localparam int unsigned ALU_WIDTH     = 8;
  localparam int unsigned BCD_DIGIT_MAX = 9;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_EOR  = 4'd4,
    ALU_ASL  = 4'd5,
    ALU_LSR  = 4'd6,
    ALU_ROL  = 4'd7,
    ALU_ROR  = 4'd8,
    ALU_PASS = 4'd9
  } aluOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
`ifdef ALU_DECIMAL_MODE_EN
    ST_DONE = 2'd2,
    ST_ADJ  = 2'd3
`else
    ST_DONE = 2'd2
`endif
  } aluState_t;

endpackage

// File: rtl/bcd_adjust.sv
// Combinational decimal correction of a binary ADD/SUB result.
// Only compiled into alu_unit when ALU_DECIMAL_MODE_EN is defined.
module bcd_adjust
  import cpu_pkg::*;
(
  input  logic [7:0] binResult,
  input  logic       halfCarry,
  input  logic       carry,
  input  logic       isSub,
  output logic [7:0] adjResult,
  output logic       adjCarry
);

  logic [8:0] addLow;
  logic       addHigh;
  logic [7:0] subLow;

  // Add path fixes the low digit first, then decides on the high digit from the fixed value.
  // Sub path uses half-carry/carry as inverted borrows; carry passes through unchanged.
  always_comb begin
    addLow    = {1'b0, binResult};
    addHigh   = 1'b0;
    subLow    = binResult;
    adjResult = binResult;
    adjCarry  = carry;
    if (!isSub) begin
      if ((binResult[3:0] > 4'(BCD_DIGIT_MAX)) || halfCarry) begin
        addLow = {1'b0, binResult} + 9'h006;
      end
      addHigh   = carry || addLow[8] || (addLow[7:4] > 4'(BCD_DIGIT_MAX));
      adjResult = addHigh ? (addLow[7:0] + 8'h60) : addLow[7:0];
      adjCarry  = addHigh;
    end else begin
      if (!halfCarry) begin
        subLow = binResult - 8'h06;
      end
      adjResult = carry ? subLow : (subLow - 8'h60);
      adjCarry  = carry;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Sequenced 8-bit ALU stage: latch on start, compute, optional BCD fix, publish with valid.
// Build option ALU_DECIMAL_MODE_EN enables the ADJ cycle and honours decimalEnable.
module alu_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  input  logic             carryIn,
  input  logic [3:0]       op,
  input  logic             decimalEnable,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflowOut,
  output logic             negativeOut,
  output logic             zeroOut
);

  aluState_t state, stateNext;
  logic      latchEn, execEn, doneEn;

  logic [WIDTH-1:0] aReg, bReg;
  logic             cinReg;
  logic [3:0]       opReg;

  logic [WIDTH-1:0] tmpRes;
  logic             tmpC, tmpV;

  logic [WIDTH:0]   sum9, diff9;
  logic [WIDTH-1:0] binRes;
  logic             binC, binV;

`ifdef ALU_DECIMAL_MODE_EN
  logic             decReg;
  logic             adjEn;
  logic             tmpH;
  logic             binH;
  logic [4:0]       lowSum;
  logic [WIDTH-1:0] adjRes;
  logic             adjC;
`else
  logic             unusedDecimal;
  assign unusedDecimal = decimalEnable;
`endif

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // Next-state and per-state datapath strobes.
  always_comb begin
    stateNext = state;
    latchEn   = 1'b0;
    execEn    = 1'b0;
    doneEn    = 1'b0;
`ifdef ALU_DECIMAL_MODE_EN
    adjEn     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          latchEn   = 1'b1;
          stateNext = ST_EXEC;
        end
      end
      ST_EXEC: begin
        execEn    = 1'b1;
        stateNext = ST_DONE;
`ifdef ALU_DECIMAL_MODE_EN
        if (decReg && ((opReg == ALU_ADD) || (opReg == ALU_SUB))) stateNext = ST_ADJ;
`endif
      end
`ifdef ALU_DECIMAL_MODE_EN
      ST_ADJ: begin
        adjEn     = 1'b1;
        stateNext = ST_DONE;
      end
`endif
      ST_DONE: begin
        doneEn    = 1'b1;
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Binary result and flags from the latched operands.
  always_comb begin
    sum9   = {1'b0, aReg} + {1'b0, bReg} + (WIDTH+1)'(cinReg);
    diff9  = {1'b0, aReg} + {1'b0, ~bReg} + (WIDTH+1)'(cinReg);
    binRes = aReg;
    binC   = cinReg;
    binV   = 1'b0;
    case (opReg)
      ALU_ADD: begin
        binRes = sum9[WIDTH-1:0];
        binC   = sum9[WIDTH];
        binV   = (aReg[WIDTH-1] == bReg[WIDTH-1]) && (sum9[WIDTH-1] != aReg[WIDTH-1]);
      end
      ALU_SUB: begin
        binRes = diff9[WIDTH-1:0];
        binC   = diff9[WIDTH];
        binV   = (aReg[WIDTH-1] != bReg[WIDTH-1]) && (diff9[WIDTH-1] != aReg[WIDTH-1]);
      end
      ALU_AND: binRes = aReg & bReg;
      ALU_OR:  binRes = aReg | bReg;
      ALU_EOR: binRes = aReg ^ bReg;
      ALU_ASL: begin
        binRes = {aReg[WIDTH-2:0], 1'b0};
        binC   = aReg[WIDTH-1];
      end
      ALU_LSR: begin
        binRes = {1'b0, aReg[WIDTH-1:1]};
        binC   = aReg[0];
      end
      ALU_ROL: begin
        binRes = {aReg[WIDTH-2:0], cinReg};
        binC   = aReg[WIDTH-1];
      end
      ALU_ROR: begin
        binRes = {cinReg, aReg[WIDTH-1:1]};
        binC   = aReg[0];
      end
      default: begin
        binRes = aReg;
        binC   = cinReg;
      end
    endcase
  end

`ifdef ALU_DECIMAL_MODE_EN
  // Carry out of bit 3; for SUB its inverse is the half-borrow.
  always_comb begin
    lowSum = {1'b0, aReg[3:0]} + {1'b0, ((opReg == ALU_SUB) ? ~bReg[3:0] : bReg[3:0])} + 5'(cinReg);
    binH   = lowSum[4];
  end

  bcd_adjust u_bcd_adjust (
    .binResult (tmpRes),
    .halfCarry (tmpH),
    .carry     (tmpC),
    .isSub     (opReg == ALU_SUB),
    .adjResult (adjRes),
    .adjCarry  (adjC)
  );
`endif

  // Operand latch, intermediate result and held outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      aReg        <= '0;
      bReg        <= '0;
      cinReg      <= 1'b0;
      opReg       <= 4'd0;
      tmpRes      <= '0;
      tmpC        <= 1'b0;
      tmpV        <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      result      <= '0;
      carryOut    <= 1'b0;
      overflowOut <= 1'b0;
      negativeOut <= 1'b0;
      zeroOut     <= 1'b0;
`ifdef ALU_DECIMAL_MODE_EN
      decReg      <= 1'b0;
      tmpH        <= 1'b0;
`endif
    end else begin
      if (latchEn) begin
        aReg   <= aIn;
        bReg   <= bIn;
        cinReg <= carryIn;
        opReg  <= op;
`ifdef ALU_DECIMAL_MODE_EN
        decReg <= decimalEnable;
`endif
      end
      if (execEn) begin
        tmpRes <= binRes;
        tmpC   <= binC;
        tmpV   <= binV;
`ifdef ALU_DECIMAL_MODE_EN
        tmpH   <= binH;
`endif
      end
`ifdef ALU_DECIMAL_MODE_EN
      if (adjEn) begin
        tmpRes <= adjRes;
        tmpC   <= adjC;
      end
      busy <= (stateNext == ST_EXEC) || (stateNext == ST_ADJ);
`else
      busy <= (stateNext == ST_EXEC);
`endif
      valid <= doneEn;
      if (doneEn) begin
        result      <= tmpRes;
        carryOut    <= tmpC;
        overflowOut <= tmpV;
        negativeOut <= tmpRes[WIDTH-1];
        zeroOut     <= (tmpRes == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed, table-driven bench for alu_unit; decimal expectations follow ALU_DECIMAL_MODE_EN.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] aIn, bIn;
  logic       carryIn;
  logic [3:0] op;
  logic       decimalEnable;
  logic       start;
  logic       busy, valid;
  logic [7:0] result;
  logic       carryOut, overflowOut, negativeOut, zeroOut;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       dec;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       n;
    logic       z;
    int         lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  alu_unit #(.WIDTH(8)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .aIn           (aIn),
    .bIn           (bIn),
    .carryIn       (carryIn),
    .op            (op),
    .decimalEnable (decimalEnable),
    .start         (start),
    .busy          (busy),
    .valid         (valid),
    .result        (result),
    .carryOut      (carryOut),
    .overflowOut   (overflowOut),
    .negativeOut   (negativeOut),
    .zeroOut       (zeroOut)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                              input logic ci, input logic d, input logic [7:0] r,
                              input logic c, input logic v, input logic n, input logic z,
                              input int l);
    vec_t t;
    t.op = o; t.a = a; t.b = b; t.cin = ci; t.dec = d;
    t.res = r; t.c = c; t.v = v; t.n = n; t.z = z; t.lat = l;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, then count edges (the start-sampling edge is 1) until valid.
  task automatic issue(input vec_t t, output int lat);
    @(negedge clk);
    aIn = t.a; bIn = t.b; carryIn = t.cin; op = t.op; decimalEnable = t.dec; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    aIn = ~t.a; bIn = ~t.b; carryIn = ~t.cin; op = 4'd2; decimalEnable = ~t.dec;
    lat = 1;
    while (!valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!valid) lat = 99;
  endtask

  int   lat;
  int   nvalid;
  logic [7:0] held;

  initial begin
    // Binary cases common to both builds.
    vecs[0]  = mk(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    vecs[1]  = mk(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    vecs[2]  = mk(4'd2, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    vecs[3]  = mk(4'd3, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    vecs[4]  = mk(4'd4, 8'hAA, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    vecs[5]  = mk(4'd5, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    vecs[6]  = mk(4'd6, 8'h01, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    vecs[7]  = mk(4'd7, 8'h40, 8'h00, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    vecs[8]  = mk(4'd8, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    vecs[9]  = mk(4'd9, 8'h7E, 8'h11, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    vecs[10] = mk(4'd12, 8'h00, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    vecs[11] = mk(4'd0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    vecs[12] = mk(4'd1, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    // Logic op with decimal requested always stays binary.
    vecs[13] = mk(4'd2, 8'hFF, 8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 3);
`ifdef ALU_DECIMAL_MODE_EN
    vecs[14] = mk(4'd0, 8'h19, 8'h28, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    vecs[15] = mk(4'd1, 8'h10, 8'h01, 1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    vecs[16] = mk(4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4);
`else
    vecs[14] = mk(4'd0, 8'h19, 8'h28, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    vecs[15] = mk(4'd1, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    vecs[16] = mk(4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b1, 1'b0, 3);
`endif

    nrst = 1'b0; aIn = 8'h00; bIn = 8'h00; carryIn = 1'b0; op = 4'd0;
    decimalEnable = 1'b0; start = 1'b0;
    #23;
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({carryOut, overflowOut, negativeOut, zeroOut}), 0);
    chk("rst_busy_valid", int'({busy, valid}), 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i], lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), int'(result), int'(vecs[i].res));
      chk($sformatf("v%0d_cvnz", i), int'({carryOut, overflowOut, negativeOut, zeroOut}),
          int'({vecs[i].c, vecs[i].v, vecs[i].n, vecs[i].z}));
      held = result;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid_drop", i), int'(valid), 0);
      chk($sformatf("v%0d_hold", i), int'(result), int'(held));
    end

    // Extra starts during EXEC and DONE must be dropped.
    @(negedge clk);
    aIn = 8'h50; bIn = 8'h50; carryIn = 1'b0; op = 4'd0; decimalEnable = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("seq_busy_exec", int'(busy), 1);
    aIn = 8'h55; bIn = 8'h00; op = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvalid = (valid === 1'b1) ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    chk("seq_ignored_valids", nvalid, 1);
    chk("seq_ignored_result", int'(result), 8'hA0);
    chk("seq_ignored_flags", int'({carryOut, overflowOut, negativeOut, zeroOut}), 4'b0110);

    // Asynchronous reset while an ADD is in EXEC.
    @(negedge clk);
    aIn = 8'h19; bIn = 8'h28; carryIn = 1'b0; op = 4'd0; decimalEnable = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_flags", int'({carryOut, overflowOut, negativeOut, zeroOut}), 0);
    chk("mid_rst_busy_valid", int'({busy, valid}), 0);
    @(negedge clk);
    nrst = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid === 1'b1) nvalid++;
    end
    chk("mid_rst_no_valid", nvalid, 0);
    chk("mid_rst_idle_busy", int'(busy), 0);

    // Recovery after reset.
    issue(vecs[8], lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_result", int'(result), 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
